// File: rtl/tcp_conn_responder.sv
// Behavioural TCP control-channel responder: listen-port table, session table with
// lowest-free allocation, and a fixed-latency open handshake.
module tcp_conn_responder #(
  parameter int unsigned LISTEN_ENTRIES = 8,
  parameter int unsigned MAX_SESSIONS   = 16,
  parameter int unsigned OPEN_LATENCY   = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             s_axis_listen_port_valid,
  output logic             s_axis_listen_port_ready,
  input  logic [15:0]      s_axis_listen_port_data,

  output logic             m_axis_listen_port_status_valid,
  input  logic             m_axis_listen_port_status_ready,
  output logic [7:0]       m_axis_listen_port_status_data,

  input  logic             s_axis_open_connection_valid,
  output logic             s_axis_open_connection_ready,
  input  logic [47:0]      s_axis_open_connection_data,

  output logic             m_axis_open_status_valid,
  input  logic             m_axis_open_status_ready,
  output logic [23:0]      m_axis_open_status_data,

  input  logic             s_axis_close_connection_valid,
  output logic             s_axis_close_connection_ready,
  input  logic [15:0]      s_axis_close_connection_data,

  output logic [3:0][31:0] status_reg
);

  localparam int unsigned LidW = (LISTEN_ENTRIES > 1) ? $clog2(LISTEN_ENTRIES) : 1;
  localparam int unsigned SidW = (MAX_SESSIONS > 1) ? $clog2(MAX_SESSIONS) : 1;

  typedef enum logic [1:0] {StIdle, StListenRsp, StOpenWait, StOpenRsp} state_e;

  state_e                    state_q;
  logic [7:0]                wait_cnt_q;
  logic                      listen_rsp_valid_q;
  logic [7:0]                listen_rsp_data_q;
  logic                      open_rsp_valid_q;
  logic [23:0]               open_rsp_data_q;
  logic [3:0][31:0]          status_q;

  logic [LISTEN_ENTRIES-1:0] lst_valid_q;
  logic [15:0]               lst_port_q [LISTEN_ENTRIES];
  logic [MAX_SESSIONS-1:0]   sess_valid_q;
  logic [31:0]               sess_ip_q [MAX_SESSIONS];
  logic [15:0]               sess_rport_q [MAX_SESSIONS];

  logic                      idle;
  logic                      close_acc;
  logic                      listen_acc;
  logic                      open_acc;

  logic                      listen_hit;
  logic                      listen_full;
  logic [LidW-1:0]           listen_free_idx;
  logic                      listen_success;
  logic                      listen_write;

  logic                      sess_free;
  logic [SidW-1:0]           sess_free_idx;
  logic [31:0]               open_ip;
  logic [15:0]               open_rport;
  logic                      open_alloc;

  logic                      close_id_ok;
  logic [SidW-1:0]           close_idx;
  logic                      close_hit;

  // Fixed priority close > listen > open, only while idle.
  assign idle       = (state_q == StIdle);
  assign close_acc  = idle && s_axis_close_connection_valid;
  assign listen_acc = idle && !s_axis_close_connection_valid && s_axis_listen_port_valid;
  assign open_acc   = idle && !s_axis_close_connection_valid && !s_axis_listen_port_valid &&
                      s_axis_open_connection_valid;

  assign s_axis_close_connection_ready = close_acc;
  assign s_axis_listen_port_ready      = listen_acc;
  assign s_axis_open_connection_ready  = open_acc;

  // Parallel compare of all listen slots plus lowest-free search.
  always_comb begin
    listen_hit      = 1'b0;
    listen_full     = 1'b1;
    listen_free_idx = '0;
    for (int i = int'(LISTEN_ENTRIES) - 1; i >= 0; i--) begin
      if (lst_valid_q[i] && (lst_port_q[i] == s_axis_listen_port_data)) listen_hit = 1'b1;
      if (!lst_valid_q[i]) begin
        listen_full     = 1'b0;
        listen_free_idx = LidW'(i);
      end
    end
  end

  assign listen_success = (s_axis_listen_port_data != 16'd0) && (listen_hit || !listen_full);
  assign listen_write   = listen_acc && (s_axis_listen_port_data != 16'd0) && !listen_hit &&
                          !listen_full;

  always_comb begin
    sess_free     = 1'b0;
    sess_free_idx = '0;
    for (int i = int'(MAX_SESSIONS) - 1; i >= 0; i--) begin
      if (!sess_valid_q[i]) begin
        sess_free     = 1'b1;
        sess_free_idx = SidW'(i);
      end
    end
  end

  assign open_ip    = s_axis_open_connection_data[31:0];
  assign open_rport = s_axis_open_connection_data[47:32];
  assign open_alloc = open_acc && (open_ip != 32'd0) && (open_rport != 16'd0) && sess_free;

  assign close_id_ok = ({16'd0, s_axis_close_connection_data} < MAX_SESSIONS);
  assign close_idx   = s_axis_close_connection_data[SidW-1:0];
  assign close_hit   = close_id_ok && sess_valid_q[close_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      wait_cnt_q         <= 8'd0;
      listen_rsp_valid_q <= 1'b0;
      listen_rsp_data_q  <= 8'd0;
      open_rsp_valid_q   <= 1'b0;
      open_rsp_data_q    <= 24'd0;
      status_q           <= '0;
      lst_valid_q        <= '0;
      sess_valid_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (close_acc) begin
            if (close_hit) begin
              sess_valid_q[close_idx] <= 1'b0;
              status_q[1]             <= status_q[1] - 32'd1;
            end else begin
              status_q[3] <= status_q[3] + 32'd1;
            end
          end else if (listen_acc) begin
            if (listen_write) begin
              lst_valid_q[listen_free_idx] <= 1'b1;
              status_q[0]                  <= status_q[0] + 32'd1;
            end
            listen_rsp_data_q  <= {7'd0, listen_success};
            listen_rsp_valid_q <= 1'b1;
            state_q            <= StListenRsp;
          end else if (open_acc) begin
            if (open_alloc) begin
              sess_valid_q[sess_free_idx] <= 1'b1;
              status_q[1]                 <= status_q[1] + 32'd1;
              open_rsp_data_q             <= {7'd0, 1'b1, 16'(sess_free_idx)};
            end else begin
              status_q[2]     <= status_q[2] + 32'd1;
              open_rsp_data_q <= {8'd0, 16'hFFFF};
            end
            wait_cnt_q <= 8'(OPEN_LATENCY);
            if (OPEN_LATENCY == 0) begin
              open_rsp_valid_q <= 1'b1;
              state_q          <= StOpenRsp;
            end else begin
              state_q <= StOpenWait;
            end
          end
        end
        StListenRsp: begin
          if (m_axis_listen_port_status_ready) begin
            listen_rsp_valid_q <= 1'b0;
            state_q            <= StIdle;
          end
        end
        StOpenWait: begin
          // Leave as the counter reaches 0 so exactly OPEN_LATENCY cycles are spent here.
          wait_cnt_q <= wait_cnt_q - 8'd1;
          if (wait_cnt_q <= 8'd1) begin
            open_rsp_valid_q <= 1'b1;
            state_q          <= StOpenRsp;
          end
        end
        StOpenRsp: begin
          if (m_axis_open_status_ready) begin
            open_rsp_valid_q <= 1'b0;
            state_q          <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Table payloads need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (listen_write) lst_port_q[listen_free_idx] <= s_axis_listen_port_data;
    if (open_alloc) begin
      sess_ip_q[sess_free_idx]    <= open_ip;
      sess_rport_q[sess_free_idx] <= open_rport;
    end
  end

  assign m_axis_listen_port_status_valid = listen_rsp_valid_q;
  assign m_axis_listen_port_status_data  = listen_rsp_data_q;
  assign m_axis_open_status_valid        = open_rsp_valid_q;
  assign m_axis_open_status_data         = open_rsp_data_q;
  assign status_reg                      = status_q;

endmodule

// File: tb/tb_tcp_conn_responder.sv
// Directed bench for tcp_conn_responder: vector table of requests plus hand-written
// priority, backpressure and mid-open reset sequences.
module tb_tcp_conn_responder;

  localparam int unsigned LAT = 4;
  localparam logic [47:0] OPEN_D = {16'd5001, 32'h0A00_0002};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lp_valid = 1'b0, lp_ready;
  logic [15:0]      lp_data = '0;
  logic             ls_valid, ls_ready = 1'b1;
  logic [7:0]       ls_data;
  logic             oc_valid = 1'b0, oc_ready;
  logic [47:0]      oc_data = '0;
  logic             os_valid, os_ready = 1'b1;
  logic [23:0]      os_data;
  logic             cc_valid = 1'b0, cc_ready;
  logic [15:0]      cc_data = '0;
  logic [3:0][31:0] status_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_conn_responder #(
    .LISTEN_ENTRIES(8),
    .MAX_SESSIONS  (16),
    .OPEN_LATENCY  (LAT)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_axis_listen_port_valid        (lp_valid),
    .s_axis_listen_port_ready        (lp_ready),
    .s_axis_listen_port_data         (lp_data),
    .m_axis_listen_port_status_valid (ls_valid),
    .m_axis_listen_port_status_ready (ls_ready),
    .m_axis_listen_port_status_data  (ls_data),
    .s_axis_open_connection_valid    (oc_valid),
    .s_axis_open_connection_ready    (oc_ready),
    .s_axis_open_connection_data     (oc_data),
    .m_axis_open_status_valid        (os_valid),
    .m_axis_open_status_ready        (os_ready),
    .m_axis_open_status_data         (os_data),
    .s_axis_close_connection_valid   (cc_valid),
    .s_axis_close_connection_ready   (cc_ready),
    .s_axis_close_connection_data    (cc_data),
    .status_reg                      (status_reg)
  );

  typedef enum {OpListen, OpOpen, OpClose, OpStat} op_e;
  typedef struct {
    op_e         op;
    logic [47:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input op_e op, input logic [47:0] data, input logic [31:0] exp);
    vec_t v;
    v.op = op;
    v.data = data;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic do_listen(input logic [15:0] port, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    lp_valid = 1'b1;
    lp_data  = port;
    #1;
    while (!lp_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("listen_accept", 32'(lp_ready), 32'd1);
    @(negedge clk);
    lp_valid = 1'b0;
    check("listen_status_valid", 32'(ls_valid), 32'd1);
    check("listen_status_data", 32'(ls_data), 32'(exp));
  endtask

  // Waits for the open response and checks it appears exactly 1+LAT cycles after accept.
  task automatic open_rsp(input logic [23:0] exp);
    int first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(negedge clk);
      if (k == 1) oc_valid = 1'b0;
      if (os_valid) first = k;
    end
    check("open_latency", 32'(first), 32'(1 + LAT));
    check("open_status_data", 32'(os_data), 32'(exp));
  endtask

  task automatic do_open(input logic [47:0] data, input logic [23:0] exp);
    int n = 0;
    @(negedge clk);
    oc_valid = 1'b1;
    oc_data  = data;
    #1;
    while (!oc_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("open_accept", 32'(oc_ready), 32'd1);
    open_rsp(exp);
  endtask

  task automatic do_close(input logic [15:0] id);
    int n = 0;
    @(negedge clk);
    cc_valid = 1'b1;
    cc_data  = id;
    #1;
    while (!cc_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("close_accept", 32'(cc_ready), 32'd1);
    @(negedge clk);
    cc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;

    add(OpListen, 48'd5001, 32'h01);
    add(OpListen, 48'd5001, 32'h01);
    add(OpListen, 48'd0,    32'h00);
    add(OpStat,   48'd0,    32'd1);
    for (int i = 0; i < 7; i++) add(OpListen, 48'(100 + i), 32'h01);
    add(OpListen, 48'd107,  32'h00);
    add(OpStat,   48'd0,    32'd8);
    add(OpOpen,   OPEN_D,   32'h010000);
    add(OpOpen,   OPEN_D,   32'h010001);
    add(OpOpen,   OPEN_D,   32'h010002);
    add(OpStat,   48'd1,    32'd3);
    add(OpClose,  48'd1,    32'd0);
    add(OpOpen,   OPEN_D,   32'h010001);
    add(OpClose,  48'd1,    32'd0);
    add(OpClose,  48'd1,    32'd0);
    add(OpStat,   48'd3,    32'd1);
    add(OpClose,  48'h0040, 32'd0);
    add(OpStat,   48'd3,    32'd2);
    add(OpStat,   48'd1,    32'd2);
    // Sessions 0 and 2 are live; the fill takes 1 then 3..15.
    for (int i = 0; i < 14; i++) add(OpOpen, OPEN_D, 32'h010000 | 32'((i == 0) ? 1 : i + 2));
    add(OpStat,   48'd1,    32'd16);
    add(OpOpen,   OPEN_D,   32'h00FFFF);
    add(OpStat,   48'd2,    32'd1);
    add(OpOpen,   {16'd5001, 32'd0}, 32'h00FFFF);
    add(OpStat,   48'd2,    32'd2);
    add(OpStat,   48'd1,    32'd16);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int w = 0; w < 4; w++) check("reset_status_reg", status_reg[w], 32'd0);
    check("reset_listen_valid", 32'(ls_valid), 32'd0);
    check("reset_open_valid", 32'(os_valid), 32'd0);
    check("reset_listen_data", 32'(ls_data), 32'd0);
    check("reset_open_data", 32'(os_data), 32'd0);

    foreach (vecs[i]) begin
      unique case (vecs[i].op)
        OpListen: do_listen(vecs[i].data[15:0], vecs[i].exp[7:0]);
        OpOpen:   do_open(vecs[i].data, vecs[i].exp[23:0]);
        OpClose:  do_close(vecs[i].data[15:0]);
        OpStat:   check($sformatf("status_reg[%0d] vec%0d", vecs[i].data[1:0], i),
                        status_reg[vecs[i].data[1:0]], vecs[i].exp);
        default:  ;
      endcase
    end

    // All three requests in one idle cycle with listen-status backpressure.
    @(negedge clk);
    ls_ready = 1'b0;
    cc_valid = 1'b1;
    cc_data  = 16'd5;
    lp_valid = 1'b1;
    lp_data  = 16'd5001;
    oc_valid = 1'b1;
    oc_data  = OPEN_D;
    #1;
    check("prio_close_ready", 32'({cc_ready, lp_ready, oc_ready}), 32'b100);
    @(negedge clk);
    cc_valid = 1'b0;
    #1;
    check("prio_close_effect", status_reg[1], 32'd15);
    check("prio_listen_ready", 32'({cc_ready, lp_ready, oc_ready}), 32'b010);
    @(negedge clk);
    lp_valid = 1'b0;
    #1;
    check("prio_listen_valid", 32'(ls_valid), 32'd1);
    check("prio_listen_data", 32'(ls_data), 32'h01);
    check("prio_open_blocked", 32'(oc_ready), 32'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (!(ls_valid === 1'b1 && ls_data === 8'h01 && oc_ready === 1'b0)) bad++;
    end
    check("backpressure_hold", 32'(bad), 32'd0);
    ls_ready = 1'b1;
    @(negedge clk);
    #1;
    check("handshake_drop_valid", 32'(ls_valid), 32'd0);
    check("open_ready_after_handshake", 32'(oc_ready), 32'd1);
    open_rsp(24'h010005);
    @(negedge clk);
    check("active_after_reuse", status_reg[1], 32'd16);

    // Reset while the (failing) open sits in OPEN_WAIT.
    @(negedge clk);
    oc_valid = 1'b1;
    oc_data  = OPEN_D;
    #1;
    check("rst_open_accept", 32'(oc_ready), 32'd1);
    @(negedge clk);
    oc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (os_valid !== 1'b0) bad++;
    end
    check("rst_open_valid_never", 32'(bad), 32'd0);
    for (int w = 0; w < 4; w++) check("rst_mid_status_reg", status_reg[w], 32'd0);
    do_open(OPEN_D, 24'h010000);
    @(negedge clk);
    check("rst_active_after_open", status_reg[1], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_conn_responder.md
# tcp_conn_responder

Stack-side responder for the host TCP control channels: it accepts listen-port, open-connection and close-connection requests over axis_meta and answers listen and open requests with status beats. It keeps a listen-port table and a session table with lowest-free session allocation, and emulates the open-handshake delay with a fixed latency. It sits behind the off-path TCP control block, either as a behavioural stand-in for the TCP offload engine in system benches or as the bring-up session manager.

## Interface
- LISTEN_ENTRIES, 8: listen-table depth (1..64).
- MAX_SESSIONS, 16: session-table depth (1..65535); valid session IDs are 0..MAX_SESSIONS-1.
- OPEN_LATENCY, 4: cycles spent in OPEN_WAIT before the open status is presented (0..255).
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_axis_listen_port  axis_meta.slave  16  port to listen on.
- m_axis_listen_port_status  axis_meta.master  8  {7'b0, success}.
- s_axis_open_connection  axis_meta.slave  48  {remote_port[47:32], remote_ip[31:0]}.
- m_axis_open_status  axis_meta.master  24  {7'b0, success, session_id[15:0]}.
- s_axis_close_connection  axis_meta.slave  16  session_id to close.
- status_reg  out  4x32  [0] listen_count, [1] active_sessions, [2] open_fail_cnt, [3] close_err_cnt.

## Operation
- FSM states: IDLE, LISTEN_RSP, OPEN_WAIT, OPEN_RSP. Only one request is processed at a time.
- In IDLE, the block picks exactly one valid input by fixed priority close > listen > open. The ready of the picked input is 1 and all other readies are 0. In every other state, all three readies are 0. Ready is combinational from state and the input valids.
- Close accept:
  - If id < MAX_SESSIONS and the entry is valid, clear the entry and decrement active_sessions.
  - Otherwise increment close_err_cnt.
  - No response beat is produced. The FSM stays in IDLE.
- Listen accept:
  - port == 0: success = 0.
  - Port already present in the table: success = 1, no new entry.
  - Table holds LISTEN_ENTRIES ports: success = 0.
  - Otherwise: write the port to the lowest free slot, increment listen_count, success = 1.
  - The lookup is a parallel compare of all slots. Go to LISTEN_RSP.
- Open accept:
  - remote_ip == 0, remote_port == 0, or no free session: success = 0, session_id = 16'hFFFF, increment open_fail_cnt.
  - Otherwise: allocate the lowest free index (priority encoder), store ip/port, set the entry valid, increment active_sessions, success = 1.
  - The entry is committed at acceptance. Load the wait counter with OPEN_LATENCY and go to OPEN_WAIT.
- OPEN_WAIT: decrement the counter each cycle. Go to OPEN_RSP on the cycle the counter is 0, so the wait lasts OPEN_LATENCY cycles. With OPEN_LATENCY = 0, go straight to OPEN_RSP.
- LISTEN_RSP / OPEN_RSP: hold valid and data stable until ready, then return to IDLE on the handshake cycle.
- Listen entries are never removed. Counters are 32-bit, wrapping; active_sessions and listen_count cannot exceed their table depths.

## Timing
- Reset: all table valid bits 0, all status_reg words 0, FSM in IDLE, both master valids 0, both status data 0, wait counter 0. A reset mid-operation discards any pending response and allocation. The first valid after reset can be accepted on the first cycle rst is low.
- Listen: accepted at cycle T, status valid at T+1.
- Open: accepted at T, status valid at T+1+OPEN_LATENCY.
- Close: accepted at T, table and status_reg updated at T+1.
- Maximum throughput:
  - Closes: 1 per cycle.
  - Listens: 1 per 2 cycles with response ready held at 1.
  - Opens: 1 per 2+OPEN_LATENCY cycles.
- The next request can be accepted in the cycle after the response handshake. The response handshake cycle itself accepts nothing.
- status_reg updates one cycle after the event that causes it.

## Test plan
- Listen on port 5001, then 5001 again, then port 0 -> status 8'h01, 8'h01, 8'h00; listen_count = 1. Then 8 distinct ports with LISTEN_ENTRIES=8 -> the first 7 return 8'h01 and the 8th returns 8'h00.
- Open {16'd5001, 32'h0A00_0002} three times with OPEN_LATENCY=4 -> statuses 24'h010000, 24'h010001, 24'h010002, each valid exactly 5 cycles after its accept; active_sessions = 3.
- Close id 1, then open again -> status 24'h010001 (lowest free reused); close id 1 twice -> second close gives close_err_cnt = 1; close id 16'h0040 with MAX_SESSIONS=16 -> close_err_cnt = 2.
- Fill all 16 sessions, then open once more -> 24'h00FFFF; open_fail_cnt = 1. Open with ip 0 -> 24'h00FFFF; open_fail_cnt = 2.
- Close, listen and open valid in the same IDLE cycle -> close accepted first, then listen, then open; hold m_axis_listen_port_status.ready = 0 for 10 cycles -> valid and data stable, no new accept.
- Assert rst during OPEN_WAIT -> m_axis_open_status.valid is never asserted, all status_reg words read 0, and the next open returns session 0.
